clock_set_ctrl: RTL and testbench

- Sequencer that owns the control inputs of the clock counter: i_ena, i_sel, i_wr and i_in.
- In RUN it produces the 1 Hz count enable.
- In edit mode it halts counting and walks the user through HH, MM, SS and PM fields, driven by debounced button pulses.
- Each up/down press issues one BCD write into the selected counter field; sits between the button debouncers and the clock counter.

---
 rtl/clock_set_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: produces the 1 Hz count enable in RUN and BCD field writes in edit mode.
// Optional edit inactivity timeout is compiled in when CLKSET_TIMEOUT_EN is defined.
module clock_set_ctrl #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BLINK_DIV = 25_000_000,
   parameter int TIMEOUT_S = 10
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_btn_mode,
   input  logic       i_btn_up,
   input  logic       i_btn_dn,
   input  logic [7:0] i_hh,
   input  logic [7:0] i_mm,
   input  logic [7:0] i_ss,
   input  logic       i_pm,
   output logic       o_ena,
   output logic       o_wr,
   output logic [1:0] o_sel,
   output logic [7:0] o_in,
   output logic [3:0] o_field,
   output logic       o_blink
);

   localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_EDIT_HH,
      ST_EDIT_MM,
      ST_EDIT_SS,
      ST_EDIT_PM
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       edit_q, edit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q, blink_d;
   logic             ena_q, ena_d;
   logic             wr_q, wr_d;
   logic [1:0]       sel_q, sel_d;
   logic [7:0]       in_q, in_d;
   logic [3:0]       field_q, field_d;
   logic [7:0]       new_val;
   logic             do_up, do_dn;

`ifdef CLKSET_TIMEOUT_EN
   localparam int TO_CYCLES = TIMEOUT_S * CLK_HZ;
   localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
   logic [TO_W-1:0] to_q, to_d;
`endif

   // Out-of-range captured values snap to the field minimum (up) or maximum (down)
   function automatic logic [7:0] hour_step(input logic [7:0] v, input logic up);
      logic valid;
      logic [7:0] r;
      valid = ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
              ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
      r = v;
      if (up) begin
         if (!valid || v == 8'h12)  r = 8'h01;
         else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
         else                       r = v + 8'd1;
      end else begin
         if (!valid || v == 8'h01)  r = 8'h12;
         else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
         else                       r = v - 8'd1;
      end
      return r;
   endfunction

   function automatic logic [7:0] sexa_step(input logic [7:0] v, input logic up);
      logic valid;
      logic [7:0] r;
      valid = (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
      r = v;
      if (up) begin
         if (!valid || v == 8'h59)  r = 8'h00;
         else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
         else                       r = v + 8'd1;
      end else begin
         if (!valid || v == 8'h00)  r = 8'h59;
         else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
         else                       r = v - 8'd1;
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      edit_d      = edit_q;
      div_d       = div_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      ena_d       = 1'b0;
      wr_d        = 1'b0;
      sel_d       = 2'd0;
      in_d        = 8'h00;
      new_val     = edit_q;
      field_d     = 4'b0000;
      do_up       = i_btn_up & ~i_btn_dn;
      do_dn       = i_btn_dn & ~i_btn_up;
`ifdef CLKSET_TIMEOUT_EN
      to_d        = to_q;
`endif

      if (state_q == ST_RUN) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            ena_d = 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
`ifdef CLKSET_TIMEOUT_EN
         to_d = '0;
`endif
         if (i_btn_mode) begin
            state_d = ST_EDIT_HH;
            edit_d  = i_hh;
         end
      end else begin
         // Divider parked at zero so the first second after leaving edit is a full period
         div_d = '0;
         if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end

         if (i_btn_mode) begin
            case (state_q)
               ST_EDIT_HH: begin state_d = ST_EDIT_MM; edit_d = i_mm; end
               ST_EDIT_MM: begin state_d = ST_EDIT_SS; edit_d = i_ss; end
               ST_EDIT_SS: begin state_d = ST_EDIT_PM; edit_d = {7'b0, i_pm}; end
               default:    state_d = ST_RUN;
            endcase
         end else if (do_up || do_dn) begin
            case (state_q)
               ST_EDIT_HH: begin new_val = hour_step(edit_q, do_up); sel_d = 2'd2; end
               ST_EDIT_MM: begin new_val = sexa_step(edit_q, do_up); sel_d = 2'd1; end
               ST_EDIT_SS: begin new_val = sexa_step(edit_q, do_up); sel_d = 2'd0; end
               default:    begin new_val = {7'b0, ~edit_q[0]};       sel_d = 2'd3; end
            endcase
            edit_d = new_val;
            in_d   = new_val;
            wr_d   = 1'b1;
            ena_d  = 1'b1;
         end

`ifdef CLKSET_TIMEOUT_EN
         if (i_btn_mode || i_btn_up || i_btn_dn) begin
            to_d = '0;
         end else if (to_q == TO_LAST) begin
            to_d    = '0;
            state_d = ST_RUN;
         end else begin
            to_d = to_q + 1'b1;
         end
`endif
      end

      if (state_d == ST_RUN) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end

      case (state_d)
         ST_EDIT_HH: field_d = 4'b0001;
         ST_EDIT_MM: field_d = 4'b0010;
         ST_EDIT_SS: field_d = 4'b0100;
         ST_EDIT_PM: field_d = 4'b1000;
         default:    field_d = 4'b0000;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_RUN;
         edit_q      <= 8'h00;
         div_q       <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         ena_q       <= 1'b0;
         wr_q        <= 1'b0;
         sel_q       <= 2'd0;
         in_q        <= 8'h00;
         field_q     <= 4'b0000;
      end else begin
         state_q     <= state_d;
         edit_q      <= edit_d;
         div_q       <= div_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         ena_q       <= ena_d;
         wr_q        <= wr_d;
         sel_q       <= sel_d;
         in_q        <= in_d;
         field_q     <= field_d;
      end
   end

`ifdef CLKSET_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) to_q <= '0;
      else            to_q <= to_d;
   end
`endif

   assign o_ena   = ena_q;
   assign o_wr    = wr_q;
   assign o_sel   = sel_q;
   assign o_in    = in_q;
   assign o_field = field_q;
   assign o_blink = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with a short tick period and blink divider.
module tb_clock_set_ctrl;

   localparam int CLK_HZ    = 10;
   localparam int BLINK_DIV = 4;
   localparam int TIMEOUT_S = 1;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_btn_mode, i_btn_up, i_btn_dn;
   logic [7:0] i_hh, i_mm, i_ss;
   logic       i_pm;
   logic       o_ena, o_wr, o_blink;
   logic [1:0] o_sel;
   logic [7:0] o_in;
   logic [3:0] o_field;

   int checkCount = 0;
   int passCount  = 0;

   clock_set_ctrl #(
      .CLK_HZ   (CLK_HZ),
      .BLINK_DIV(BLINK_DIV),
      .TIMEOUT_S(TIMEOUT_S)
   ) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_btn_mode(i_btn_mode),
      .i_btn_up  (i_btn_up),
      .i_btn_dn  (i_btn_dn),
      .i_hh      (i_hh),
      .i_mm      (i_mm),
      .i_ss      (i_ss),
      .i_pm      (i_pm),
      .o_ena     (o_ena),
      .o_wr      (o_wr),
      .o_sel     (o_sel),
      .o_in      (o_in),
      .o_field   (o_field),
      .o_blink   (o_blink)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // Drive button pulses for one cycle, then sample just after the capturing edge
   task automatic applyStimulus(input logic mode, input logic up, input logic dn);
      i_btn_mode = mode;
      i_btn_up   = up;
      i_btn_dn   = dn;
      @(posedge i_clk);
      #1;
      i_btn_mode = 1'b0;
      i_btn_up   = 1'b0;
      i_btn_dn   = 1'b0;
   endtask

   task automatic checkWrite(input string tag, input logic [1:0] sel, input logic [7:0] value);
      checkOutput({tag, "_wr"},  32'(o_wr),  32'd1);
      checkOutput({tag, "_ena"}, 32'(o_ena), 32'd1);
      checkOutput({tag, "_sel"}, 32'(o_sel), 32'(sel));
      checkOutput({tag, "_in"},  32'(o_in),  32'(value));
   endtask

   // One full pass through the edit fields with a single press in each of HH, MM, SS
   task automatic testArith(input logic [7:0] hh, input logic hup, input logic [7:0] hexp,
                            input logic [7:0] mm, input logic mup, input logic [7:0] mexp,
                            input logic [7:0] ss, input logic sup, input logic [7:0] sexp);
      i_hh = hh;
      i_mm = mm;
      i_ss = ss;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, hup, ~hup);
      checkWrite($sformatf("arith_hh_%02h", hh), 2'd2, hexp);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, mup, ~mup);
      checkWrite($sformatf("arith_mm_%02h", mm), 2'd1, mexp);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, sup, ~sup);
      checkWrite($sformatf("arith_ss_%02h", ss), 2'd0, sexp);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("arith_exit_field", 32'(o_field), 32'h0);
   endtask

   initial begin
      i_reset_n  = 1'b0;
      i_btn_mode = 1'b0;
      i_btn_up   = 1'b0;
      i_btn_dn   = 1'b0;
      i_hh       = 8'h12;
      i_mm       = 8'h00;
      i_ss       = 8'h00;
      i_pm       = 1'b0;

      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("reset_ena",   32'(o_ena),   32'h0);
      checkOutput("reset_wr",    32'(o_wr),    32'h0);
      checkOutput("reset_sel",   32'(o_sel),   32'h0);
      checkOutput("reset_in",    32'(o_in),    32'h0);
      checkOutput("reset_field", 32'(o_field), 32'h0);
      checkOutput("reset_blink", 32'(o_blink), 32'h0);
      @(negedge i_clk);
      i_reset_n = 1'b1;

      // Free-running RUN: tick on every tenth edge after reset release
      for (int k = 1; k <= 35; k++) begin
         @(posedge i_clk);
         #1;
         checkOutput($sformatf("run_tick_%0d", k), 32'(o_ena), 32'((k % 10) == 0));
         checkOutput($sformatf("run_wr_%0d", k),   32'(o_wr),  32'h0);
      end

      // Enter EDIT_HH with 12 captured; up wraps to 01
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("hh_entry_field", 32'(o_field), 32'b0001);
      checkOutput("hh_entry_wr",    32'(o_wr),    32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkWrite("hh_up_wrap", 2'd2, 8'h01);
      for (int k = 2; k <= 9; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("edit_no_tick_%0d", k), 32'(o_ena),   32'h0);
         checkOutput($sformatf("edit_blink_%0d", k),   32'(o_blink), 32'((k / 4) % 2));
      end

      i_mm = 8'h37;
      i_ss = 8'h00;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("mm_entry_field", 32'(o_field), 32'b0010);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("mode_up_field", 32'(o_field), 32'b0100);
      checkOutput("mode_up_wr",    32'(o_wr),    32'h0);
      checkOutput("mode_up_ena",   32'(o_ena),   32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("up_dn_wr",    32'(o_wr),    32'h0);
      checkOutput("up_dn_field", 32'(o_field), 32'b0100);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkWrite("ss_dn_wrap", 2'd0, 8'h59);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkWrite("ss_up_first", 2'd0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkWrite("ss_up_second", 2'd0, 8'h01);

      i_pm = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("pm_entry_field", 32'(o_field), 32'b1000);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkWrite("pm_toggle", 2'd3, 8'h01);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("exit_field", 32'(o_field), 32'h0);
      checkOutput("exit_blink", 32'(o_blink), 32'h0);
      checkOutput("exit_wr",    32'(o_wr),    32'h0);
      for (int k = 1; k <= 10; k++) begin
         @(posedge i_clk);
         #1;
         checkOutput($sformatf("exit_tick_%0d", k), 32'(o_ena), 32'(k == 10));
      end

      testArith(8'h09, 1'b1, 8'h10,  8'h59, 1'b1, 8'h00,  8'h00, 1'b0, 8'h59);
      testArith(8'h12, 1'b0, 8'h11,  8'h29, 1'b1, 8'h30,  8'h40, 1'b0, 8'h39);
      testArith(8'h10, 1'b0, 8'h09,  8'h00, 1'b0, 8'h59,  8'h09, 1'b1, 8'h10);
      testArith(8'h00, 1'b1, 8'h01,  8'h60, 1'b1, 8'h00,  8'h7F, 1'b0, 8'h59);
      testArith(8'h1A, 1'b0, 8'h12,  8'h5A, 1'b0, 8'h59,  8'h35, 1'b1, 8'h36);
      testArith(8'h01, 1'b0, 8'h12,  8'h12, 1'b0, 8'h11,  8'h58, 1'b1, 8'h59);

      // Inactivity in edit: leaves after ten idle cycles only when the timeout is built in
      i_hh = 8'h05;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("idle_entry_field", 32'(o_field), 32'b0001);
      repeat (9) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_9_field", 32'(o_field), 32'b0001);
      applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef CLKSET_TIMEOUT_EN
      checkOutput("idle_10_field", 32'(o_field), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0);
`else
      checkOutput("idle_10_field", 32'(o_field), 32'b0001);
`endif

      // Asynchronous reset in the middle of a write cycle
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkWrite("pre_reset_write", 2'd2, 8'h06);
      #2;
      i_reset_n = 1'b0;
      #1;
      checkOutput("async_reset_wr",    32'(o_wr),    32'h0);
      checkOutput("async_reset_ena",   32'(o_ena),   32'h0);
      checkOutput("async_reset_field", 32'(o_field), 32'h0);
      checkOutput("async_reset_in",    32'(o_in),    32'h0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("post_reset_up_ignored", 32'(o_wr),    32'h0);
      checkOutput("post_reset_field",      32'(o_field), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
